// File: rtl/rst_pkg.sv
// Shared definitions for the reset pulse generator.
//   state_t      : sequencer states (IDLE, ASSERT, HOLDOFF)
//   CAUSE_*      : bit positions inside the sticky cause register
package rst_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam int unsigned CAUSE_SW   = 0;
  localparam int unsigned CAUSE_BTN  = 1;
  localparam int unsigned CAUSE_WDOG = 2;

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on each debounced press.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset (debouncer returns to released)
//   btn_n  in  raw asynchronous button, active low
//   press  out one-cycle pulse when the button becomes debounced-pressed
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          pressed;
  logic [CW-1:0] cnt;
  logic          differs;

  // The counter only runs while the synchronized level disagrees with the
  // debounced state; any sample that agrees (a bounce) restarts it.
  assign differs = (~sync2) != pressed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      pressed <= 1'b0;
      cnt     <= RELOAD;
      press   <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (!differs) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        pressed <= ~pressed;
        cnt     <= RELOAD;
        press   <= ~pressed;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rst_pulse_gen.sv
// Reset initiator: merges software, push-button and watchdog requests into
// one RST_n low pulse of ASSERT_CYCLES clocks followed by a HOLDOFF_CYCLES
// window, and keeps a sticky record of which sources caused resets.
// Optional watchdog: define RST_PULSE_WDOG_EN to build it; otherwise
// wdog_kick is ignored and cause[2] stays 0.
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-high reset (restarts power-on pulse)
//   sw_req     in  single-cycle software reset request
//   btn_n      in  raw asynchronous push-button, active low
//   wdog_kick  in  single-cycle watchdog reload
//   cause_clr  in  single-cycle clear of cause
//   RST_n      out registered active-low reset to rst_synch instances
//   busy       out high whenever the sequencer is not IDLE
//   cause      out sticky {wdog, btn, sw} of accepted requests
module rst_pulse_gen
  import rst_pkg::*;
#(
  parameter int unsigned ASSERT_CYCLES   = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned WDOG_CYCLES     = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_req,
  input  logic       btn_n,
  input  logic       wdog_kick,
  input  logic       cause_clr,
  output logic       RST_n,
  output logic       busy,
  output logic [2:0] cause
);

  localparam int unsigned CNT_MAX =
    (ASSERT_CYCLES > HOLDOFF_CYCLES) ? ASSERT_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] A_RELOAD = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] H_RELOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             pending;
  logic             pending_n;
  logic             btn_press;
  logic             wdog_expire;
  logic [2:0]       set_bits;
  logic             req;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_n),
    .press (btn_press)
  );

`ifdef RST_PULSE_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] W_RELOAD = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wcnt;

  // A kick in the expiry cycle suppresses the expiry.
  assign wdog_expire = (state == IDLE) && (wcnt == '0) && !wdog_kick;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= W_RELOAD;
    end else if (wdog_kick || (state != IDLE) || (wcnt == '0)) begin
      wcnt <= W_RELOAD;
    end else begin
      wcnt <= wcnt - 1'b1;
    end
  end
`else
  logic [31:0] wdog_unused;
  assign wdog_unused = 32'(WDOG_CYCLES) ^ {31'b0, wdog_kick};
  assign wdog_expire = 1'b0;
`endif

  always_comb begin
    set_bits             = '0;
    set_bits[CAUSE_SW]   = sw_req;
    set_bits[CAUSE_BTN]  = btn_press;
    set_bits[CAUSE_WDOG] = wdog_expire;
  end

  assign req = |set_bits;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pending_n = pending;
    case (state)
      IDLE: begin
        if (req || pending) begin
          state_n   = ASSERT;
          cnt_n     = A_RELOAD;
          pending_n = 1'b0;
        end
      end
      ASSERT: begin
        // A request during the pulse restarts the full low time.
        if (req) begin
          cnt_n = A_RELOAD;
        end else if (cnt == '0) begin
          state_n = HOLDOFF;
          cnt_n   = H_RELOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLDOFF: begin
        if (req) begin
          pending_n = 1'b1;
        end
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = ASSERT;
        cnt_n   = A_RELOAD;
      end
    endcase
  end

  // RST_n and busy are registered from the next state so they change on
  // the same edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ASSERT;
      cnt     <= A_RELOAD;
      pending <= 1'b0;
      RST_n   <= 1'b0;
      busy    <= 1'b1;
      cause   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      RST_n   <= (state_n != ASSERT);
      busy    <= (state_n != IDLE);
      cause   <= (cause & ~{3{cause_clr}}) | set_bits;
    end
  end

endmodule

// File: tb/tb_rst_pulse_gen.sv
// Testbench for rst_pulse_gen with ASSERT=16, HOLDOFF=8, DEBOUNCE=4, WDOG=32.
module tb_rst_pulse_gen;

  localparam int unsigned A_CYC = 16;
  localparam int unsigned H_CYC = 8;
  localparam int unsigned D_CYC = 4;
  localparam int unsigned W_CYC = 32;

  typedef struct {
    int unsigned reps;
    logic        sw_req;
    logic        cause_clr;
    logic        exp_rst_n;
    logic        exp_busy;
    logic [2:0]  exp_cause;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_req = 1'b0;
  logic       btn_n = 1'b1;
  logic       wdog_kick = 1'b0;
  logic       cause_clr = 1'b0;
  logic       RST_n;
  logic       busy;
  logic [2:0] cause;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          auto_kick = 1'b1;
  int unsigned kphase = 0;
  vec_t        vecs[12];

  always #5 clk = ~clk;

  rst_pulse_gen #(
    .ASSERT_CYCLES   (A_CYC),
    .HOLDOFF_CYCLES  (H_CYC),
    .DEBOUNCE_CYCLES (D_CYC),
    .WDOG_CYCLES     (W_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_req    (sw_req),
    .btn_n     (btn_n),
    .wdog_kick (wdog_kick),
    .cause_clr (cause_clr),
    .RST_n     (RST_n),
    .busy      (busy),
    .cause     (cause)
  );

  // One clock: optional periodic kick keeps the watchdog quiet in IDLE.
  task automatic tick();
    if (auto_kick) begin
      wdog_kick = (kphase == 0);
      kphase = (kphase + 1) % 16;
    end
    @(posedge clk);
    #1;
    if (auto_kick) wdog_kick = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic r, input logic b, input logic [2:0] c);
    chk({name, " RST_n"}, 32'(RST_n), 32'(r));
    chk({name, " busy"}, 32'(busy), 32'(b));
    chk({name, " cause"}, 32'(cause), 32'(c));
  endtask

  task automatic run_count(input int unsigned n, output int unsigned f);
    logic p;
    p = RST_n;
    f = 0;
    repeat (n) begin
      tick();
      if (p && !RST_n) f++;
      p = RST_n;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned f1;
    int unsigned f2;

    vecs[0]  = '{15, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[1]  = '{8,  1'b0, 1'b0, 1'b1, 1'b1, 3'b000};
    vecs[2]  = '{3,  1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
    vecs[3]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 3'b001};
    vecs[4]  = '{15, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
    vecs[5]  = '{8,  1'b0, 1'b0, 1'b1, 1'b1, 3'b001};
    vecs[6]  = '{2,  1'b0, 1'b0, 1'b1, 1'b0, 3'b001};
    vecs[7]  = '{1,  1'b0, 1'b1, 1'b1, 1'b0, 3'b000};
    vecs[8]  = '{1,  1'b1, 1'b1, 1'b0, 1'b1, 3'b001};
    vecs[9]  = '{15, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
    vecs[10] = '{8,  1'b0, 1'b0, 1'b1, 1'b1, 3'b001};
    vecs[11] = '{2,  1'b0, 1'b0, 1'b1, 1'b0, 3'b001};

    repeat (3) tick();
    chk_out("reset", 1'b0, 1'b1, 3'b000);
    rst = 1'b0;

    // Power-on pulse, sw request, cause clear, clear+set
    for (int i = 0; i < 12; i++) begin
      for (int unsigned r = 0; r < vecs[i].reps; r++) begin
        sw_req    = vecs[i].sw_req;
        cause_clr = vecs[i].cause_clr;
        tick();
        sw_req    = 1'b0;
        cause_clr = 1'b0;
        chk_out($sformatf("vec%0d.%0d", i, r), vecs[i].exp_rst_n,
                vecs[i].exp_busy, vecs[i].exp_cause);
      end
    end

    // Request at ASSERT count 3 extends the pulse to 16 clocks after it
    sw_req = 1'b1; tick(); sw_req = 1'b0;
    repeat (12) tick();
    sw_req = 1'b1; tick(); sw_req = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("ext low %0d", k), 32'(RST_n), 32'd0);
    end
    tick();
    chk("ext release", 32'(RST_n), 32'd1);
    repeat (8) tick();
    chk("ext idle busy", 32'(busy), 32'd0);

    // Request during HOLDOFF is deferred until IDLE, then ASSERT next edge
    sw_req = 1'b1; tick(); sw_req = 1'b0;
    repeat (16) tick();
    chk("hold enter RST_n", 32'(RST_n), 32'd1);
    repeat (2) tick();
    sw_req = 1'b1; tick(); sw_req = 1'b0;
    chk_out("hold req", 1'b1, 1'b1, 3'b001);
    repeat (4) tick();
    chk("hold busy", 32'(busy), 32'd1);
    tick();
    chk_out("hold idle", 1'b1, 1'b0, 3'b001);
    tick();
    chk_out("hold reassert", 1'b0, 1'b1, 3'b001);

    // rst mid-ASSERT restarts a full pulse and clears cause
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_out("midrst", 1'b0, 1'b1, 3'b000);
    repeat (15) tick();
    chk("midrst low", 32'(RST_n), 32'd0);
    tick();
    chk("midrst release", 32'(RST_n), 32'd1);
    repeat (8) tick();
    chk("midrst idle busy", 32'(busy), 32'd0);

    // Button: short glitch, clean press, long hold
    btn_n = 1'b0; run_count(3, f1); btn_n = 1'b1;
    run_count(30, f2);
    chk("glitch falls", f1 + f2, 0);
    btn_n = 1'b0; run_count(10, f1); btn_n = 1'b1;
    run_count(40, f2);
    chk("press falls", f1 + f2, 1);
    chk("press cause", 32'(cause), 32'b010);
    cause_clr = 1'b1; tick(); cause_clr = 1'b0;
    chk("press clr", 32'(cause), 32'b000);
    btn_n = 1'b0; run_count(100, f1); btn_n = 1'b1;
    run_count(40, f2);
    chk("hold falls", f1 + f2, 1);
    chk("hold cause", 32'(cause), 32'b010);

    // Watchdog: regular kicks, then starve it
    cause_clr = 1'b1; tick(); cause_clr = 1'b0;
    auto_kick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wdog_kick = 1'b1; tick(); wdog_kick = 1'b0;
      run_count(19, f1);
      chk($sformatf("kick falls %0d", i), f1, 0);
    end
    repeat (12) tick();
    chk("wdog pre-expiry", 32'(RST_n), 32'd1);
    tick();
`ifdef RST_PULSE_WDOG_EN
    chk_out("wdog expiry", 1'b0, 1'b1, 3'b100);
    repeat (30) tick();
    chk("wdog done busy", 32'(busy), 32'd0);
`else
    chk_out("no wdog", 1'b1, 1'b0, 3'b000);
    run_count(60, f1);
    chk("no wdog falls", f1, 0);
    chk("no wdog cause", 32'(cause), 32'b000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_pulse_gen.md
Name: rst_pulse_gen

Overview:
- Reset initiator that drives the active-low RST_n input of every downstream rst_synch instance.
- Merges three reset sources (software request, debounced push-button, watchdog expiry) into one clean RST_n pulse of guaranteed minimum width, followed by a hold-off window.
- Records the cause of the last reset in a sticky register for software to read.
- Sits at top level, clocked by the always-running board clock, ahead of all reset synchronizers.

Parameters:
- ASSERT_CYCLES, 16, clocks RST_n is held low per reset event (>=2)
- HOLDOFF_CYCLES, 8, clocks after RST_n release during which new requests are deferred (>=1)
- DEBOUNCE_CYCLES, 1024, clocks the synchronized button must be stable low to count as a press (>=1)
- WDOG_CYCLES, 65536, watchdog timeout in clocks without a kick (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset of this block
- sw_req  in  1  single-cycle software reset request
- btn_n  in  1  raw asynchronous push-button, active low
- wdog_kick  in  1  single-cycle watchdog reload
- cause_clr  in  1  single-cycle clear of cause
- RST_n  out  1  registered active-low reset to rst_synch instances
- busy  out  1  high whenever state != IDLE
- cause  out  3  sticky {wdog, btn, sw} of accepted requests

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs registered.
- rst values: state=ASSERT, assert counter=ASSERT_CYCLES-1, RST_n=0, busy=1, cause=3'b000, pending=0, watchdog counter=WDOG_CYCLES-1, debouncer idle (released).
- Power-on: after rst falls, RST_n stays low exactly ASSERT_CYCLES clocks, then HOLDOFF, then IDLE.
- req = sw_req | btn_press | wdog_expire, where btn_press is a 1-cycle debounced falling-edge event.
- IDLE: RST_n=1. If req (or pending) at edge N -> ASSERT; RST_n low from edge N+1 for exactly ASSERT_CYCLES clocks; pending cleared.
- ASSERT: counter decrements. A new req reloads the counter (pulse extended) and ORs its cause bit. At 0 -> HOLDOFF, RST_n=1 on the same edge.
- HOLDOFF: RST_n=1, counter HOLDOFF_CYCLES-1 down to 0, then IDLE. A req here sets pending and its cause bit. If pending, IDLE goes to ASSERT on the next edge.
- cause: a bit is set when its source request is accepted in any state; cleared by cause_clr.
  - Set and clear in the same cycle: set wins.
  - Simultaneous sources set multiple bits.
- Watchdog:
  - Counts down every clock in IDLE.
  - Held at reload while busy.
  - wdog_kick reloads it.
  - Reaching 0 gives a 1-cycle wdog_expire, then reloads.
  - Kick and expiry in the same cycle: kick wins, no expiry.
- Button:
  - 2-flop synchronizer, then counter.
  - Stable low for DEBOUNCE_CYCLES -> pressed (one press pulse).
  - Stable high for DEBOUNCE_CYCLES -> released.
  - Any bounce restarts the count.
  - Holding the button low produces only one press.
- rst mid-sequence: restarts the power-on sequence from full ASSERT_CYCLES.
- Counter widths: $clog2(param+1) bits. No wrap: counters saturate at 0 and are only reloaded explicitly.

Optional Feature:
- RST_PULSE_WDOG_EN defined: watchdog logic as above; cause[2] live.
- Not defined: no watchdog counter; wdog_kick ignored; wdog_expire tied 0; cause[2] constant 0.

Decomposition:
- Shared package rst_pkg:
  - state enum {IDLE, ASSERT, HOLDOFF}
  - cause bit index constants CAUSE_SW=0, CAUSE_BTN=1, CAUSE_WDOG=2
- Sub-module btn_debounce (clk, rst, btn_n, press): synchronizer + debounce counter + edge pulse.

Test Plan:
- Release rst at cycle 0 -> RST_n=0 cycles 0..15, RST_n=1 at 16, busy=1 through cycle 23, busy=0 at 24, cause=000.
- sw_req pulse in IDLE at edge N -> RST_n low edges N+1..N+16, cause=001; cause_clr -> 000. cause_clr and sw_req in the same cycle -> cause=001.
- DEBOUNCE_CYCLES=4: btn_n glitch low 3 cycles -> no reset. Low 10 cycles -> exactly one reset, cause=010. Held low 100 cycles -> still one reset.
- WDOG_CYCLES=32, RST_PULSE_WDOG_EN defined:
  - kick every 20 cycles -> no reset.
  - Stop kicking -> reset 32 cycles after the last kick, cause=100.
  - Without the macro -> never resets, cause[2]=0.
- sw_req at ASSERT count 3 -> RST_n low extended to 16 clocks after that request. sw_req during HOLDOFF -> new ASSERT one cycle after IDLE is reached.
- Assert rst for 1 cycle mid-ASSERT -> cause=000, fresh 16-cycle RST_n low.
